param_updown_counter: RTL

- Parametrised successor to the existing 16-bit enable-gated up counter used as a qlf_k4n8 placement/timing test design.
- Adds the following features:
  - configurable width and modulo limit
  - up/down direction
  - synchronous clear and load
  - clock-enable prescaler
  - wrap or saturate mode
  - terminal-count pulse and sticky overflow flag
- With default parameters and up_down=1, saturate=0, load=0, clear=0, it is cycle-identical to the legacy 16-bit up counter.
- Intended as a synthesis/placement test design with a self-checking bench.

---
 rtl/param_updown_counter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised up/down counter with a modulo limit, clock-enable prescaler,
// wrap or saturate behaviour, synchronous clear/load, a terminal-count pulse
// and a sticky overflow flag. With default parameters, counting up, wrapping
// and no clear/load, it behaves exactly like a plain 16-bit enabled counter.
//
// Parameters:
//   WIDTH      counter width in bits (2..32)
//   MAX_VALUE  highest count value, count range is 0..MAX_VALUE
//   PRESCALE   enabled cycles per count step (1..256)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   enable      count enable, advances the prescaler
//   clear       synchronous clear of count, prescaler, tick and tc
//   load        synchronous load of load_value (clamped to MAX_VALUE)
//   load_value  value used by load
//   up_down     1 = count up, 0 = count down
//   saturate    1 = hold at the limit, 0 = wrap around
//   ovf_clear   synchronous clear of the overflow flag
//   count       current count (registered)
//   tick        one-cycle pulse after every qualifying step
//   tc          one-cycle pulse after a step that hit a boundary
//   overflow    sticky boundary-event flag
// ---------------------------------------------------------------------------
module param_updown_counter #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  MAX_VALUE = {WIDTH{1'b1}},
  parameter int                PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             saturate,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             overflow
);

  localparam logic [7:0]       PC_LAST = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [7:0]       pc_r;
  logic [7:0]       pc_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic             tick_r;
  logic             tick_s;
  logic             tc_r;
  logic             tc_s;
  logic             ovf_r;
  logic             ovf_s;
  logic             step_s;
  logic             bound_s;

  // Next-state logic: clear > load > prescaled step, then flag updates.
  always_comb begin
    pc_s    = pc_r;
    count_s = count_r;
    step_s  = 1'b0;
    bound_s = 1'b0;

    if (clear) begin
      count_s = ZERO;
      pc_s    = 8'd0;
    end else if (load) begin
      count_s = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
      pc_s    = 8'd0;
    end else if (enable) begin
      if (pc_r == PC_LAST) begin
        pc_s   = 8'd0;
        step_s = 1'b1;
      end else begin
        pc_s   = pc_r + 8'd1;
      end
    end else begin
      pc_s = pc_r;
    end

    if (step_s) begin
      if (up_down) begin
        // ">=" so that an out-of-range count is treated as the upper boundary.
        if (count_r >= MAX_VALUE) begin
          bound_s = 1'b1;
          count_s = saturate ? count_r : ZERO;
        end else begin
          count_s = count_r + ONE;
        end
      end else begin
        if (count_r == ZERO) begin
          bound_s = 1'b1;
          count_s = saturate ? count_r : MAX_VALUE;
        end else begin
          count_s = count_r - ONE;
        end
      end
    end else begin
      bound_s = 1'b0;
    end

    tick_s = step_s;
    tc_s   = bound_s;

    // A boundary event on the same edge as ovf_clear keeps the flag set.
    if (bound_s) begin
      ovf_s = 1'b1;
    end else if (ovf_clear) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r    <= 8'd0;
      count_r <= ZERO;
      tick_r  <= 1'b0;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      pc_r    <= pc_s;
      count_r <= count_s;
      tick_r  <= tick_s;
      tc_r    <= tc_s;
      ovf_r   <= ovf_s;
    end
  end

  assign count    = count_r;
  assign tick     = tick_r;
  assign tc       = tc_r;
  assign overflow = ovf_r;

endmodule
